bios_loader: RTL

Boot-time copy engine that moves a program image from the disk/storage interface into instruction memory, one word at a time, under BIOS control. The BIOS fires `start` with source, destination and length; the loader runs its own read/write handshake and pulses `done`, after which BIOS issues `UPMEM` so `bios_control` switches fetch to memory. The loader drives the instruction memory write port only while `busy` is high.

---
 rtl/bios_loader.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bios_loader.sv
// bios_loader: boot-time copy engine. Moves a program image from the disk
// interface into instruction memory one word at a time, then pulses done.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   start               begin a transfer (sampled only in IDLE)
//   srcBase/dstBase     first disk / memory word address
//   length              word count, 0..2^ADDR_WIDTH
//   expectedSum         reference checksum (checksum build only)
//   diskReq/diskAddr    read request, held until diskAck
//   diskAck/diskData    read data valid this cycle
//   memWe/memAddr/memData  instruction memory write port (one cycle per word)
//   busy, done          not-IDLE flag, one-cycle completion pulse
//   count               words written in the current/last transfer
//   checksum, sumError  running sum of written words, mismatch flag
//
// Build option: define BIOS_LOADER_CHECKSUM_EN to enable checksum/sumError;
// otherwise both are tied to zero and expectedSum is ignored.

module bios_loader #(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 10,
  parameter int DISK_ADDR_WIDTH = 12
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [DISK_ADDR_WIDTH-1:0] srcBase,
  input  logic [ADDR_WIDTH-1:0]      dstBase,
  input  logic [ADDR_WIDTH:0]        length,
  input  logic [DATA_WIDTH-1:0]      expectedSum,
  output logic                       diskReq,
  output logic [DISK_ADDR_WIDTH-1:0] diskAddr,
  input  logic                       diskAck,
  input  logic [DATA_WIDTH-1:0]      diskData,
  output logic                       memWe,
  output logic [ADDR_WIDTH-1:0]      memAddr,
  output logic [DATA_WIDTH-1:0]      memData,
  output logic                       busy,
  output logic                       done,
  output logic [ADDR_WIDTH:0]        count,
  output logic [DATA_WIDTH-1:0]      checksum,
  output logic                       sumError
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                     state, state_next;
  logic [DISK_ADDR_WIDTH-1:0] src;
  logic [ADDR_WIDTH-1:0]      dst;
  logic [ADDR_WIDTH:0]        len;
  logic [ADDR_WIDTH:0]        cnt;
  logic [ADDR_WIDTH:0]        cnt_inc;
  logic [DATA_WIDTH-1:0]      word;
  logic                       last_word;

  assign cnt_inc   = cnt + 1'b1;
  assign last_word = (cnt_inc == len);

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = (length != '0) ? READ : DONE;
      READ:  if (diskAck) state_next = WRITE;
      WRITE: state_next = last_word ? DONE : READ;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: latched transfer parameters, captured word, word counter.
  // Addresses wrap naturally at their register width.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src  <= '0;
      dst  <= '0;
      len  <= '0;
      cnt  <= '0;
      word <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          src <= srcBase;
          dst <= dstBase;
          len <= length;
          cnt <= '0;
        end
        READ: if (diskAck) word <= diskData;
        WRITE: begin
          cnt <= cnt_inc;
          src <= src + 1'b1;
          dst <= dst + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign diskReq  = (state == READ);
  assign diskAddr = src;
  assign memWe    = (state == WRITE);
  assign memAddr  = dst;
  assign memData  = word;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign count    = cnt;

`ifdef BIOS_LOADER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] sum_next;
  logic                  err;

  assign sum_next = sum + word;

  // The error flag is evaluated on the edge that enters DONE, so it has to
  // compare the sum including the word being written on that same edge.
  // A zero-length transfer enters DONE straight from IDLE with a cleared sum.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sum <= '0;
          err <= (length == '0) ? (expectedSum != '0) : 1'b0;
        end
        WRITE: begin
          sum <= sum_next;
          if (last_word) err <= (sum_next != expectedSum);
        end
        default: ;
      endcase
    end
  end

  assign checksum = sum;
  assign sumError = err;
`else
  logic unused_expected_sum;
  assign unused_expected_sum = ^expectedSum;
  assign checksum = '0;
  assign sumError = 1'b0;
`endif

endmodule
